vga_cursor_engine: RTL and testbench
====================================

VGA_CURSOR_ENGINE -- requirements
Module: vga_cursor_engine

Interface
REQ-001 Parameter NUM_CURSORS, default 2: number of independent cursor channels, range 1..8.
REQ-002 Parameter CELL_W_LOG2, default 3: log2 of character cell width in pixels.
REQ-003 Parameter CELL_H_LOG2, default 4: log2 of character cell height in scanlines.
REQ-004 Parameter PRESCALE, default 390625: clocks per blink tick, minimum 1.
REQ-005 Parameter PIPE_DELAY, default 1: output register stages for alignment with the pixel pipeline, minimum 1.
REQ-006 clk  in  1  pixel clock; the block has one clock; reset is asynchronous and active-high.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 frame_start  in  1  one-cycle pulse at frame origin from the scan generator.
REQ-009 h_coord  in  10  current pixel column.
REQ-010 v_coord  in  9  current scanline.
REQ-011 ctrl  in  32*NUM_CURSORS  per-cursor control word, cursor i at bits [32i+31:32i].
REQ-012 cursor_hit  out  NUM_CURSORS  per-cursor "pixel inside visible cursor".
REQ-013 cursor_any  out  1  OR of cursor_hit.
REQ-014 cursor_id  out  3  index of lowest-numbered set cursor_hit bit; 0 when none.

Function
REQ-015 ctrl word fields: [7:0] column, [13:8] row, [15:14] shape (00 block, 01 underline, 10 bar, 11 disabled), [23:16] blink period in ticks (0 = steady on), [31:24] ignored.
REQ-016 ctrl is sampled into per-cursor shadow registers only in the cycle frame_start=1; matching uses shadow values only, so no mid-frame tearing.
REQ-017 Cell match: h_coord>>CELL_W_LOG2 equals column AND v_coord>>CELL_H_LOG2 equals row, compared at full field width; out-of-range positions never match.
REQ-018 Shape block: whole cell; underline: the last 2 scanlines of the cell; bar: the first 2 pixel columns of the cell; disabled: never hits.
REQ-019 Prescaler counts down from PRESCALE-1 to 0 and reloads; tick is asserted in the cycle the count is 0.
REQ-020 Each cursor has an 8-bit blink counter and a phase bit; phase=1 means visible.
REQ-021 On tick with period != 0: if counter==0, toggle phase and reload period-1; else decrement. Phase therefore toggles every `period` ticks.
REQ-022 When period==0, phase is held at 1 and the counter is held at 0.
REQ-023 A shadow update that changes a cursor's period forces phase=1 and counter=new period-1 in that cycle, overriding a simultaneous tick for that cursor only.
REQ-024 The raw hit is match AND shape AND phase; it passes through PIPE_DELAY registers. Coordinates presented at cycle t produce outputs at cycle t+PIPE_DELAY.
REQ-025 cursor_any and cursor_id are computed from the delayed hit vector, with the same latency as cursor_hit.
REQ-026 Overlapping cursors may all assert their hit bits; priority applies only to cursor_id.

Reset
REQ-027 rst clears the prescaler, all blink counters, and all pipeline stages to 0; sets all phases to 1; sets all shadow shapes to 11 (disabled) and the other shadow fields to 0.
REQ-028 Following REQ-027, cursor_hit, cursor_any and cursor_id are 0 during reset and until the first frame_start after release.
REQ-029 Reset asserted mid-frame or mid-blink takes effect immediately with no partial state retained.

Structure
REQ-030 A shared package holds the shape encodings, the ctrl field bit positions and the ctrl word width constant (32).
REQ-031 One sub-module, vga_cursor_channel, holds the shadow registers, the blink counter/phase and the raw hit for one cursor; it is instantiated NUM_CURSORS times by generate. The prescaler, pipeline and priority encoder live in the top level.

Verification
REQ-032 Bench uses PRESCALE=4 and PIPE_DELAY=2. Cursor0 ctrl=0x0000_0305 (col 5, row 3, block, steady) with frame_start pulsed; scan h=40..47, v=48..63. Required: cursor_hit[0]=1 exactly 2 cycles after each such coordinate, and 0 at h=39 and h=48.
REQ-033 Cursor0 shape=01 at col 5, row 3. Required: hits only for v=62 and v=63 within the cell; shape=10 hits only for h=40 and h=41.
REQ-034 Cursor0 block, period=2. Required: phase toggles every 8 clocks (2 ticks x 4); visible/hidden pattern is checked over 64 clocks starting with visible.
REQ-035 Change ctrl mid-frame to col 6. Required: hits stay at col 5 until the next frame_start pulse, then move to col 6.
REQ-036 Cursors 0 and 1 both at col 2, row 1, block, steady. Required: cursor_hit=2'b11, cursor_any=1, cursor_id=0; disabling cursor0 then gives cursor_id=1.
REQ-037 Assert rst mid-blink while hits are active. Required: all outputs are 0 within the reset cycle's output stage, and no hit occurs after release until frame_start.

Source files
------------

// File: rtl/vga_cursor_engine_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_cursor_engine_pkg
// Description : Shared definitions for the VGA cursor engine: cursor shape
//               encodings, control-word field positions and control-word
//               width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package vga_cursor_engine_pkg;

    localparam int C_CTRL_W       = 32;

    localparam int C_COL_LSB      = 0;
    localparam int C_COL_W        = 8;
    localparam int C_ROW_LSB      = 8;
    localparam int C_ROW_W        = 6;
    localparam int C_SHAPE_LSB    = 14;
    localparam int C_SHAPE_W      = 2;
    localparam int C_PERIOD_LSB   = 16;
    localparam int C_PERIOD_W     = 8;

    typedef enum logic [1:0] {
        SHAPE_BLOCK     = 2'b00,
        SHAPE_UNDERLINE = 2'b01,
        SHAPE_BAR       = 2'b10,
        SHAPE_DISABLED  = 2'b11
    } shape_e;

endpackage : vga_cursor_engine_pkg
`default_nettype wire

// File: rtl/vga_cursor_channel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_cursor_channel
// Description : One cursor channel. Holds the frame-synchronous shadow copy
//               of the control word, the blink counter and phase, and
//               produces the unregistered raw hit for the current pixel.
// Ports       : clk, rst          - clock, async active-high reset
//               frame_start_i     - shadow load strobe
//               ctrl_i            - control word for this cursor
//               tick_i            - blink prescaler tick
//               h_coord_i/v_coord_i - current pixel position
//               hit_o             - raw hit (match & shape & phase)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_cursor_channel
    import vga_cursor_engine_pkg::*;
#(
    parameter int CELL_W_LOG2 = 3,
    parameter int CELL_H_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start_i,
    input  logic [C_CTRL_W-1:0] ctrl_i,
    input  logic                tick_i,
    input  logic [9:0]          h_coord_i,
    input  logic [8:0]          v_coord_i,
    output logic                hit_o
);

    localparam logic [CELL_H_LOG2-1:0] C_V_OFF_LAST = '1;

    logic [C_COL_W-1:0]    col_q;
    logic [C_ROW_W-1:0]    row_q;
    shape_e                shape_q;
    logic [C_PERIOD_W-1:0] period_q;
    logic [C_PERIOD_W-1:0] cnt_q,   cnt_d;
    logic                  phase_q, phase_d;

    logic [C_PERIOD_W-1:0] new_period;
    assign new_period = ctrl_i[C_PERIOD_LSB +: C_PERIOD_W];

    // Blink next state. A period change at a shadow load restarts the blink
    // visible and wins over a coincident tick.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (frame_start_i && (new_period != period_q)) begin
            phase_d = 1'b1;
            cnt_d   = (new_period == '0) ? '0 : new_period - 8'd1;
        end else if (period_q == '0) begin
            phase_d = 1'b1;
            cnt_d   = '0;
        end else if (tick_i) begin
            if (cnt_q == '0) begin
                phase_d = ~phase_q;
                cnt_d   = period_q - 8'd1;
            end else begin
                cnt_d   = cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            shape_q  <= SHAPE_DISABLED;
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
        end else begin
            if (frame_start_i) begin
                col_q    <= ctrl_i[C_COL_LSB +: C_COL_W];
                row_q    <= ctrl_i[C_ROW_LSB +: C_ROW_W];
                shape_q  <= shape_e'(ctrl_i[C_SHAPE_LSB +: C_SHAPE_W]);
                period_q <= new_period;
            end
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // Cell match at full coordinate width so columns/rows beyond the screen
    // can never alias onto a visible cell.
    logic [9:0]             h_cell;
    logic [8:0]             v_cell;
    logic [CELL_W_LOG2-1:0] h_off;
    logic [CELL_H_LOG2-1:0] v_off;
    logic                   cell_match;
    logic                   shape_hit;

    assign h_cell     = h_coord_i >> CELL_W_LOG2;
    assign v_cell     = v_coord_i >> CELL_H_LOG2;
    assign h_off      = h_coord_i[CELL_W_LOG2-1:0];
    assign v_off      = v_coord_i[CELL_H_LOG2-1:0];
    assign cell_match = (h_cell == 10'(col_q)) && (v_cell == 9'(row_q));

    // Underline: last two scanlines share every offset bit above bit 0 with
    // the last scanline. Bar: first two columns have all upper bits clear.
    always_comb begin
        shape_hit = 1'b0;
        case (shape_q)
            SHAPE_BLOCK:     shape_hit = 1'b1;
            SHAPE_UNDERLINE: shape_hit = ((v_off >> 1) == (C_V_OFF_LAST >> 1));
            SHAPE_BAR:       shape_hit = ((h_off >> 1) == '0);
            default:         shape_hit = 1'b0;
        endcase
    end

    assign hit_o = cell_match & shape_hit & phase_q;

endmodule : vga_cursor_channel
`default_nettype wire

// File: rtl/vga_cursor_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_cursor_engine
// Description : Multi-channel text-mode cursor overlay. Shared blink
//               prescaler, NUM_CURSORS cursor channels, output alignment
//               pipeline and lowest-index priority encoder.
// Ports       : clk, rst       - pixel clock, async active-high reset
//               frame_start_i  - frame origin pulse (shadow load)
//               h_coord_i      - pixel column
//               v_coord_i      - scanline
//               ctrl_i         - packed per-cursor control words
//               cursor_hit_o   - per-cursor hit, PIPE_DELAY cycles late
//               cursor_any_o   - OR of cursor_hit_o
//               cursor_id_o    - lowest set hit index, 0 when none
// Revision    : 1.0 - initial release
// ============================================================================
module vga_cursor_engine
    import vga_cursor_engine_pkg::*;
#(
    parameter int NUM_CURSORS = 2,
    parameter int CELL_W_LOG2 = 3,
    parameter int CELL_H_LOG2 = 4,
    parameter int PRESCALE    = 390625,
    parameter int PIPE_DELAY  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame_start_i,
    input  logic [9:0]                      h_coord_i,
    input  logic [8:0]                      v_coord_i,
    input  logic [C_CTRL_W*NUM_CURSORS-1:0] ctrl_i,
    output logic [NUM_CURSORS-1:0]          cursor_hit_o,
    output logic                            cursor_any_o,
    output logic [2:0]                      cursor_id_o
);

    localparam int            C_PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [C_PS_W-1:0] C_PS_RELOAD = C_PS_W'(PRESCALE - 1);

    // Blink prescaler: tick in the cycle the down-counter reads zero.
    logic [C_PS_W-1:0] ps_q, ps_d;
    logic              tick;

    assign tick = (ps_q == '0);
    assign ps_d = tick ? C_PS_RELOAD : ps_q - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    logic [NUM_CURSORS-1:0] raw_hit;

    for (genvar gi = 0; gi < NUM_CURSORS; gi++) begin : g_channel
        vga_cursor_channel #(
            .CELL_W_LOG2 (CELL_W_LOG2),
            .CELL_H_LOG2 (CELL_H_LOG2)
        ) u_channel (
            .clk           (clk),
            .rst           (rst),
            .frame_start_i (frame_start_i),
            .ctrl_i        (ctrl_i[gi*C_CTRL_W +: C_CTRL_W]),
            .tick_i        (tick),
            .h_coord_i     (h_coord_i),
            .v_coord_i     (v_coord_i),
            .hit_o         (raw_hit[gi])
        );
    end

    // Alignment pipeline toward the pixel datapath.
    logic [NUM_CURSORS-1:0] pipe_q [PIPE_DELAY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= raw_hit;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign cursor_hit_o = pipe_q[PIPE_DELAY-1];
    assign cursor_any_o = |cursor_hit_o;

    // Scan from the top so the lowest-numbered set bit is the last writer.
    always_comb begin
        cursor_id_o = '0;
        for (int i = NUM_CURSORS - 1; i >= 0; i--) begin
            if (cursor_hit_o[i]) begin
                cursor_id_o = 3'(i);
            end
        end
    end

endmodule : vga_cursor_engine
`default_nettype wire

// File: tb/tb_vga_cursor_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_cursor_engine
// Description : Self-checking bench for vga_cursor_engine with a
//               cycle-level behavioural model plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_cursor_engine;

    localparam int N  = 2;
    localparam int PS = 4;
    localparam int PD = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            frame_start = 1'b0;
    logic [9:0]      h = '0;
    logic [8:0]      v = '0;
    logic [32*N-1:0] ctrl = {32'h0000_C000, 32'h0000_C000};
    logic [N-1:0]    cursor_hit;
    logic            cursor_any;
    logic [2:0]      cursor_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_cursor_engine #(
        .NUM_CURSORS (N),
        .CELL_W_LOG2 (3),
        .CELL_H_LOG2 (4),
        .PRESCALE    (PS),
        .PIPE_DELAY  (PD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start_i (frame_start),
        .h_coord_i     (h),
        .v_coord_i     (v),
        .ctrl_i        (ctrl),
        .cursor_hit_o  (cursor_hit),
        .cursor_any_o  (cursor_any),
        .cursor_id_o   (cursor_id)
    );

    // ------------------------------------------------------------------
    // Behavioural model: shadow fields, ticks elapsed since the blink was
    // (re)started, and a delay line of raw hit vectors.
    // ------------------------------------------------------------------
    int           m_col [N];
    int           m_row [N];
    int           m_shape [N];
    int           m_per [N];
    int           m_n [N];
    int           m_cyc;
    logic [N-1:0] m_pipe [PD];
    logic [N-1:0] m_raw;
    logic         m_tick;
    int           m_np;
    logic [N-1:0] e_hit;
    logic         e_any;
    int           e_id;

    function automatic bit model_hit(input int i, input int ph, input int pv);
        bit in_cell, in_shape, visible;
        in_cell = (ph / 8 == m_col[i]) && (pv / 16 == m_row[i]);
        case (m_shape[i])
            0:       in_shape = 1'b1;
            1:       in_shape = (pv % 16) >= 14;
            2:       in_shape = (ph % 8) < 2;
            default: in_shape = 1'b0;
        endcase
        visible = (m_per[i] == 0) || (((m_n[i] / m_per[i]) % 2) == 0);
        return in_cell && in_shape && visible;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_col[i] = 0; m_row[i] = 0; m_shape[i] = 3; m_per[i] = 0; m_n[i] = 0;
            end
            for (int k = 0; k < PD; k++) m_pipe[k] = '0;
            m_cyc = 0;
        end else begin
            m_tick = ((m_cyc % PS) == 0);
            m_cyc++;
            m_raw = '0;
            for (int i = 0; i < N; i++) m_raw[i] = model_hit(i, int'(h), int'(v));
            for (int k = PD - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
            m_pipe[0] = m_raw;
            for (int i = 0; i < N; i++) begin
                m_np = int'(ctrl[32*i+16 +: 8]);
                if (frame_start && (m_np != m_per[i])) m_n[i] = 0;
                else if (m_tick) m_n[i]++;
                if (frame_start) begin
                    m_col[i]   = int'(ctrl[32*i +: 8]);
                    m_row[i]   = int'(ctrl[32*i+8 +: 6]);
                    m_shape[i] = int'(ctrl[32*i+14 +: 2]);
                    m_per[i]   = m_np;
                end
            end
        end
        e_hit = m_pipe[PD-1];
        e_any = |e_hit;
        e_id  = 0;
        for (int i = N - 1; i >= 0; i--) if (e_hit[i]) e_id = i;
        #1;
        checks++;
        if (cursor_hit !== e_hit || cursor_any !== e_any || int'(cursor_id) != e_id) begin
            errors++;
            $display("FAIL model t=%0t: hit=%b any=%b id=%0d, expected hit=%b any=%b id=%0d",
                     $time, cursor_hit, cursor_any, cursor_id, e_hit, e_any, e_id);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic check_out(input string name, input logic [N-1:0] eh,
                             input logic ea, input logic [2:0] eid);
        checks++;
        if (cursor_hit !== eh || cursor_any !== ea || cursor_id !== eid) begin
            errors++;
            $display("FAIL %s: hit=%b any=%b id=%0d, expected hit=%b any=%b id=%0d",
                     name, cursor_hit, cursor_any, cursor_id, eh, ea, eid);
        end
    endtask

    task automatic probe(input string name, input logic [9:0] ph, input logic [8:0] pv,
                         input logic [N-1:0] eh, input logic ea, input logic [2:0] eid);
        @(negedge clk);
        h = ph; v = pv;
        repeat (3) @(posedge clk);
        #1;
        check_out(name, eh, ea, eid);
    endtask

    task automatic pulse_frame();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
    endtask

    task automatic set_ctrl(input logic [31:0] c0, input logic [31:0] c1);
        @(negedge clk);
        ctrl = {c1, c0};
    endtask

    task automatic scan(input int h0, input int h1, input int v0, input int v1);
        for (int yy = v0; yy <= v1; yy++) begin
            for (int xx = h0; xx <= h1; xx++) begin
                @(negedge clk);
                h = 10'(xx); v = 9'(yy);
            end
        end
    endtask

    logic s [64];
    int   run_len [$];
    int   cur_run;
    logic any_hit;

    initial begin
        repeat (3) @(posedge clk);
        #1 check_out("reset_outputs", 2'b00, 1'b0, 3'd0);
        @(negedge clk) rst = 1'b0;

        // Steady block cursor at col 5, row 3; no hit before frame_start.
        set_ctrl(32'h0000_0305, 32'h0000_C000);
        probe("pre_frame_no_hit", 10'd40, 9'd48, 2'b00, 1'b0, 3'd0);
        pulse_frame();
        probe("block_tl",      10'd40, 9'd48, 2'b01, 1'b1, 3'd0);
        probe("block_br",      10'd47, 9'd63, 2'b01, 1'b1, 3'd0);
        probe("block_h39",     10'd39, 9'd50, 2'b00, 1'b0, 3'd0);
        probe("block_h48",     10'd48, 9'd50, 2'b00, 1'b0, 3'd0);
        probe("block_v47",     10'd42, 9'd47, 2'b00, 1'b0, 3'd0);
        probe("block_v64",     10'd42, 9'd64, 2'b00, 1'b0, 3'd0);
        scan(39, 48, 47, 64);

        // Underline and bar shapes.
        set_ctrl(32'h0000_4305, 32'h0000_C000);
        pulse_frame();
        probe("underline_v62", 10'd44, 9'd62, 2'b01, 1'b1, 3'd0);
        probe("underline_v61", 10'd44, 9'd61, 2'b00, 1'b0, 3'd0);
        scan(39, 48, 47, 64);
        set_ctrl(32'h0000_8305, 32'h0000_C000);
        pulse_frame();
        probe("bar_h41",       10'd41, 9'd50, 2'b01, 1'b1, 3'd0);
        probe("bar_h42",       10'd42, 9'd50, 2'b00, 1'b0, 3'd0);
        scan(39, 48, 47, 64);

        // Blink with period 2: 8-clock visible/hidden runs.
        set_ctrl(32'h0002_0305, 32'h0000_C000);
        @(negedge clk);
        h = 10'd42; v = 9'd52;
        pulse_frame();
        @(posedge clk);
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1 s[i] = cursor_hit[0];
        end
        checks++;
        if (s[0] !== 1'b1) begin
            errors++;
            $display("FAIL blink_start: hit=%b, expected 1", s[0]);
        end
        run_len.delete();
        cur_run = 1;
        for (int i = 1; i < 64; i++) begin
            if (s[i] === s[i-1]) cur_run++;
            else begin run_len.push_back(cur_run); cur_run = 1; end
        end
        checks++;
        if (run_len.size() < 6) begin
            errors++;
            $display("FAIL blink_runs: run count=%0d, expected at least 6", run_len.size());
        end
        for (int i = 1; i < run_len.size(); i++) begin
            checks++;
            if (run_len[i] != 8) begin
                errors++;
                $display("FAIL blink_run_len: run %0d length=%0d, expected 8", i, run_len[i]);
            end
        end

        // Mid-frame ctrl change only takes effect at the next frame_start.
        set_ctrl(32'h0000_0305, 32'h0000_C000);
        pulse_frame();
        set_ctrl(32'h0000_0306, 32'h0000_C000);
        probe("shadow_old_col", 10'd40, 9'd50, 2'b01, 1'b1, 3'd0);
        probe("shadow_new_col_pending", 10'd48, 9'd50, 2'b00, 1'b0, 3'd0);
        pulse_frame();
        probe("shadow_new_col", 10'd48, 9'd50, 2'b01, 1'b1, 3'd0);
        probe("shadow_old_gone", 10'd40, 9'd50, 2'b00, 1'b0, 3'd0);

        // Overlap and priority.
        set_ctrl(32'h0000_0102, 32'h0000_0102);
        pulse_frame();
        probe("overlap_both",  10'd16, 9'd16, 2'b11, 1'b1, 3'd0);
        set_ctrl(32'h0000_C102, 32'h0000_0102);
        pulse_frame();
        probe("overlap_c1",    10'd23, 9'd31, 2'b10, 1'b1, 3'd1);

        // Reset mid-blink while hitting.
        set_ctrl(32'h0003_0102, 32'h0000_C000);
        pulse_frame();
        probe("pre_reset_hit", 10'd17, 9'd20, 2'b01, 1'b1, 3'd0);
        @(negedge clk) rst = 1'b1;
        #1 check_out("reset_immediate", 2'b00, 1'b0, 3'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        any_hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 if (cursor_hit !== 2'b00 || cursor_any !== 1'b0) any_hit = 1'b1;
        end
        checks++;
        if (any_hit) begin
            errors++;
            $display("FAIL post_reset_quiet: hit seen=1, expected 0");
        end
        pulse_frame();
        probe("post_reset_frame", 10'd17, 9'd20, 2'b01, 1'b1, 3'd0);

        repeat (4) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule : tb_vga_cursor_engine
`default_nettype wire
